// File: rtl/net_tx_arb_pkg.sv
// Shared network-layer transmit definitions: arbiter FSM states, requester
// slot assignments and default framing constants.
package net_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam int REQ_ARP  = 0;
    localparam int REQ_ICMP = 1;
    localparam int REQ_UDP  = 2;

    localparam int DEF_NUM_REQ         = 3;
    localparam int DEF_IFG_CYCLES      = 12;
    localparam int DEF_MAX_FRAME_BYTES = 1500;

endpackage

// File: rtl/net_tx_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after
// i_last, wrapping modulo NUM_REQ.
module net_tx_arb_rr_pick
    import net_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_last,
    output logic [$clog2(NUM_REQ)-1:0] o_grant,
    output logic                       o_any
);

    localparam int IW = $clog2(NUM_REQ);

    // Walk from the farthest candidate to the nearest so the nearest wins.
    always_comb begin : p_pick
        int idx;
        idx     = 0;
        o_grant = i_last;
        o_any   = |i_req;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(i_last) + k) % NUM_REQ;
            if (i_req[idx]) begin
                o_grant = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/net_tx_arb.sv
// Frame-granular round-robin arbiter feeding the MAC transmit stream; whole
// frames only, enforced inter-frame gap, oversize frames truncated and drained.
module net_tx_arb
    import net_tx_arb_pkg::*;
#(
    parameter int NUM_REQ         = DEF_NUM_REQ,
    parameter int IFG_CYCLES      = DEF_IFG_CYCLES,
    parameter int MAX_FRAME_BYTES = DEF_MAX_FRAME_BYTES
) (
    input  logic                       logic_clk,
    input  logic                       logic_rstn,
    input  logic [8*NUM_REQ-1:0]       req_data_in,
    input  logic [NUM_REQ-1:0]         req_valid_in,
    output logic [NUM_REQ-1:0]         req_ready_out,
    input  logic [NUM_REQ-1:0]         req_last_in,
    output logic [7:0]                 arb_tdata_out,
    output logic                       arb_tvalid_out,
    input  logic                       arb_tready_in,
    output logic                       arb_tlast_out,
    output logic [$clog2(NUM_REQ)-1:0] arb_tsrc_out,
    output logic                       arb_busy_out,
    output logic                       arb_trunc_err_out
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_FRAME_BYTES + 1);
    localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_FRAME_BYTES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
    localparam state_t DONE_STATE = (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;

    state_t          r_state;
    state_t          w_state_next;
    logic [IW-1:0]   r_grant;
    logic [IW-1:0]   r_last_grant;
    logic [IW-1:0]   w_pick;
    logic            w_any;
    logic [CW-1:0]   r_cnt;
    logic [GW-1:0]   r_gap_cnt;
    logic            r_busy;
    logic            r_trunc;

    logic [7:0]      w_bytes [NUM_REQ];
    logic [7:0]      w_sel_data;
    logic            w_sel_valid;
    logic            w_sel_last;
    logic            w_in_xfer;
    logic            w_in_drain;
    logic            w_at_max;
    logic            w_hs;
    logic            w_frame_end;

    net_tx_arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_req   (req_valid_in),
        .i_last  (r_last_grant),
        .o_grant (w_pick),
        .o_any   (w_any)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign w_bytes[gi] = req_data_in[8*gi +: 8];
            // Drain swallows the oversize tail regardless of MAC backpressure.
            assign req_ready_out[gi] = (r_grant == IW'(gi)) &&
                                       ((w_in_xfer && arb_tready_in) || w_in_drain);
        end
    endgenerate

    assign w_sel_data  = w_bytes[r_grant];
    assign w_sel_valid = req_valid_in[r_grant];
    assign w_sel_last  = req_last_in[r_grant];
    assign w_in_xfer   = (r_state == ST_XFER);
    assign w_in_drain  = (r_state == ST_DRAIN);
    assign w_at_max    = (r_cnt == CNT_LAST);
    assign w_hs        = w_in_xfer && w_sel_valid && arb_tready_in;
    assign w_frame_end = (w_hs || (w_in_drain && w_sel_valid)) && w_sel_last;

    assign arb_tdata_out     = w_in_xfer ? w_sel_data : 8'h00;
    assign arb_tvalid_out    = w_in_xfer && w_sel_valid;
    assign arb_tlast_out     = w_in_xfer && (w_sel_last || w_at_max);
    assign arb_tsrc_out      = r_grant;
    assign arb_busy_out      = r_busy;
    assign arb_trunc_err_out = r_trunc;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_any) w_state_next = ST_XFER;
            ST_XFER: begin
                if (w_frame_end) begin
                    w_state_next = DONE_STATE;
                end else if (w_hs && w_at_max) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: if (w_frame_end) w_state_next = DONE_STATE;
            ST_GAP:   if (r_gap_cnt == GAP_LAST) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge logic_clk or negedge logic_rstn) begin
        if (!logic_rstn) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= IW'(NUM_REQ - 1);
            r_cnt        <= '0;
            r_gap_cnt    <= '0;
            r_busy       <= 1'b0;
            r_trunc      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != ST_IDLE);
            r_trunc <= w_hs && !w_sel_last && w_at_max;
            if (r_state == ST_IDLE && w_any) begin
                r_grant <= w_pick;
            end
            if (r_state == ST_IDLE) begin
                r_cnt <= '0;
            end else if (w_hs) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == ST_GAP) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end else begin
                r_gap_cnt <= '0;
            end
            if (w_frame_end) begin
                r_last_grant <= r_grant;
            end
        end
    end

endmodule

// File: tb/tb_net_tx_arb.sv
// Bench for net_tx_arb: directed scenarios plus randomized frames, checked each
// cycle against a frame-level reference model of the arbitration rules.
module tb_net_tx_arb;

    localparam int N    = 3;
    localparam int IFG  = 12;
    localparam int MAXB = 8;
    localparam int IW   = $clog2(N);

    logic           clk = 1'b0;
    logic           rstn = 1'b1;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     tdata;
    logic           tvalid;
    logic           tready = 1'b0;
    logic           tlast;
    logic [IW-1:0]  tsrc;
    logic           busy;
    logic           trunc;

    logic [8*N-1:0] z_data = '0;
    logic [N-1:0]   z_valid = '0;
    logic [N-1:0]   z_last = '0;
    logic [N-1:0]   z_ready;
    logic [7:0]     z_tdata;
    logic           z_tvalid;
    logic           z_tready = 1'b0;
    logic           z_tlast;
    logic [IW-1:0]  z_tsrc;
    logic           z_busy;
    logic           z_trunc;

    always #5 clk = ~clk;

    net_tx_arb #(.NUM_REQ(N), .IFG_CYCLES(IFG), .MAX_FRAME_BYTES(MAXB)) dut (
        .logic_clk(clk), .logic_rstn(rstn),
        .req_data_in(req_data), .req_valid_in(req_valid), .req_ready_out(req_ready),
        .req_last_in(req_last), .arb_tdata_out(tdata), .arb_tvalid_out(tvalid),
        .arb_tready_in(tready), .arb_tlast_out(tlast), .arb_tsrc_out(tsrc),
        .arb_busy_out(busy), .arb_trunc_err_out(trunc)
    );

    net_tx_arb #(.NUM_REQ(N), .IFG_CYCLES(0), .MAX_FRAME_BYTES(MAXB)) dut_z (
        .logic_clk(clk), .logic_rstn(rstn),
        .req_data_in(z_data), .req_valid_in(z_valid), .req_ready_out(z_ready),
        .req_last_in(z_last), .arb_tdata_out(z_tdata), .arb_tvalid_out(z_tvalid),
        .arb_tready_in(z_tready), .arb_tlast_out(z_tlast), .arb_tsrc_out(z_tsrc),
        .arb_busy_out(z_busy), .arb_trunc_err_out(z_trunc)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Requester drivers: pending frame lengths, byte position, held byte.
    int         flen_q [N][$];
    int         fb     [N];
    logic [7:0] cur_byte [N];
    int         drop_pct = 0;
    int         rdy_pct  = 100;
    int         stall_left = 0;

    // Reference model, frame level: who owns the link and when it frees up.
    longint t = 0;
    bit     m_act = 1'b0;
    bit     m_drain = 1'b0;
    int     m_src = 0;
    int     m_cnt = 0;
    int     m_last = N - 1;
    longint m_free = 0;
    longint m_trunc_due = -1;

    int obs_bytes = 0;
    int trunc_seen = 0;
    int obs_order[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit drivers_empty();
        for (int i = 0; i < N; i++) if (flen_q[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (flen_q[i].size() > 0) begin
                req_valid[i] = (fb[i] == 0) || ($urandom_range(99) >= drop_pct);
                req_last[i]  = (fb[i] == flen_q[i][0] - 1);
                req_data[8*i +: 8] = cur_byte[i];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
                req_data[8*i +: 8] = 8'h00;
            end
        end
        if (stall_left > 0) begin
            tready = 1'b0;
            stall_left--;
        end else begin
            tready = ($urandom_range(99) < rdy_pct);
        end
    endtask

    task automatic load(input int i, input int len);
        if (flen_q[i].size() == 0) begin
            fb[i] = 0;
            cur_byte[i] = 8'($urandom);
        end
        flen_q[i].push_back(len);
    endtask

    task automatic tick();
        logic [N-1:0] exp_rdy;
        logic [N-1:0] hs_vec;
        bit hs;
        @(negedge clk);
        exp_rdy = '0;
        if (m_act) exp_rdy[m_src] = m_drain ? 1'b1 : tready;
        check("ready", 32'(req_ready), 32'(exp_rdy));
        check("busy", 32'(busy), 32'(m_act || (t < m_free)));
        check("trunc", 32'(trunc), 32'(t == m_trunc_due));
        check("tvalid", 32'(tvalid), 32'(m_act && !m_drain && req_valid[m_src]));
        if (m_act && !m_drain && req_valid[m_src]) begin
            check("tdata", 32'(tdata), 32'(req_data[8*m_src +: 8]));
            check("tlast", 32'(tlast), 32'(req_last[m_src] || (m_cnt == MAXB - 1)));
        end
        if (m_act) check("tsrc", 32'(tsrc), 32'(m_src));
        if (tvalid && tready) begin
            obs_bytes++;
            if (tlast) obs_order.push_back(int'(tsrc));
        end
        if (trunc) trunc_seen++;

        hs_vec = '0;
        if (m_act) begin
            hs = req_valid[m_src] && (m_drain || tready);
            if (hs) begin
                hs_vec[m_src] = 1'b1;
                if (req_last[m_src]) begin
                    m_act  = 1'b0;
                    m_last = m_src;
                    m_free = t + 1 + IFG;
                end else if (!m_drain && m_cnt == MAXB - 1) begin
                    m_drain     = 1'b1;
                    m_trunc_due = t + 1;
                end
                m_cnt++;
            end
        end else if (t >= m_free && |req_valid) begin
            for (int k = N; k >= 1; k--) begin
                if (req_valid[(m_last + k) % N]) m_src = (m_last + k) % N;
            end
            m_act   = 1'b1;
            m_drain = 1'b0;
            m_cnt   = 0;
        end

        @(posedge clk);
        #1;
        t++;
        for (int i = 0; i < N; i++) begin
            if (hs_vec[i]) begin
                fb[i]++;
                cur_byte[i] = 8'($urandom);
                if (fb[i] == flen_q[i][0]) begin
                    void'(flen_q[i].pop_front());
                    fb[i] = 0;
                end
            end
        end
        drive();
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!(drivers_empty() && !m_act && t >= m_free) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
    endtask

    task automatic reset_dut(input string tag);
        rstn = 1'b0;
        #1;
        check({tag, "_tvalid"}, 32'(tvalid), 32'd0);
        check({tag, "_tlast"},  32'(tlast),  32'd0);
        check({tag, "_tdata"},  32'(tdata),  32'd0);
        check({tag, "_ready"},  32'(req_ready), 32'd0);
        check({tag, "_busy"},   32'(busy),   32'd0);
        check({tag, "_tsrc"},   32'(tsrc),   32'd0);
        check({tag, "_trunc"},  32'(trunc),  32'd0);
        for (int i = 0; i < N; i++) begin
            flen_q[i].delete();
            fb[i] = 0;
        end
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tready    = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        m_act = 1'b0; m_drain = 1'b0; m_cnt = 0;
        m_last = N - 1; m_free = 0; m_trunc_due = -1;
    endtask

    initial begin
        int n;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        reset_dut("rst_init");

        // Only req1, one 4-byte frame, MAC always ready.
        drop_pct = 0; rdy_pct = 100; obs_bytes = 0; obs_order.delete();
        load(1, 4);
        drive();
        run_until_done("a_done", 200);
        check("a_bytes", 32'(obs_bytes), 32'd4);
        check("a_frames", 32'(obs_order.size()), 32'd1);
        if (obs_order.size() > 0) check("a_src", 32'(obs_order[0]), 32'd1);

        // Fresh round-robin: all three continuously valid with 3-byte frames.
        reset_dut("rst_b");
        obs_bytes = 0; obs_order.delete();
        for (int f = 0; f < 2; f++) for (int i = 0; i < N; i++) load(i, 3);
        drive();
        run_until_done("b_done", 400);
        check("b_frames", 32'(obs_order.size()), 32'd6);
        for (int k = 0; k < obs_order.size() && k < 6; k++)
            check($sformatf("b_order%0d", k), 32'(obs_order[k]), 32'(k % N));

        // MAC stall of 5 cycles in the middle of a 6-byte frame.
        obs_bytes = 0;
        load(0, 6);
        drive();
        n = 0;
        while (!(m_act && m_cnt == 2) && n < 100) begin tick(); n++; end
        check("c_reach_mid", 32'(n < 100), 32'd1);
        tready = 1'b0;
        stall_left = 4;
        run_until_done("c_done", 200);
        check("c_bytes", 32'(obs_bytes), 32'd6);

        // Oversize frame from req2: 11 bytes against an 8-byte limit.
        obs_bytes = 0; trunc_seen = 0; obs_order.delete();
        load(2, 11);
        drive();
        run_until_done("d_done", 200);
        check("d_bytes", 32'(obs_bytes), 32'd8);
        check("d_trunc_pulses", 32'(trunc_seen), 32'd1);
        check("d_frames", 32'(obs_order.size()), 32'd1);

        // Randomized traffic: valid gaps, MAC backpressure, some oversize frames.
        drop_pct = 25; rdy_pct = 70;
        for (int i = 0; i < N; i++) for (int f = 0; f < 4; f++) load(i, $urandom_range(1, 12));
        drive();
        run_until_done("r_done", 3000);

        // Reset while req1 presents byte 3, then req0 and req1 compete.
        drop_pct = 0; rdy_pct = 100;
        load(1, 6);
        drive();
        n = 0;
        while (!(m_act && fb[1] == 2) && n < 100) begin tick(); n++; end
        check("e_reach_b3", 32'(n < 100), 32'd1);
        #2;
        reset_dut("rst_mid");
        obs_order.delete();
        load(0, 2);
        load(1, 2);
        drive();
        run_until_done("e_done", 200);
        check("e_frames", 32'(obs_order.size()), 32'd2);
        if (obs_order.size() > 0) check("e_first_src", 32'(obs_order[0]), 32'd0);

        // Zero-gap instance: req0 sends two single-byte frames back to back.
        z_tready = 1'b1;
        z_data[7:0] = 8'hA5;
        z_valid = 3'b001;
        z_last  = 3'b001;
        @(negedge clk);
        check("z_arb_tvalid", 32'(z_tvalid), 32'd0);
        check("z_arb_busy", 32'(z_busy), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("z_b1_tvalid", 32'(z_tvalid), 32'd1);
        check("z_b1_tdata", 32'(z_tdata), 32'hA5);
        check("z_b1_tlast", 32'(z_tlast), 32'd1);
        check("z_b1_ready", 32'(z_ready), 32'd1);
        @(posedge clk); #1;
        z_data[7:0] = 8'h3C;
        @(negedge clk);
        check("z_idle_tvalid", 32'(z_tvalid), 32'd0);
        check("z_idle_busy", 32'(z_busy), 32'd0);
        check("z_idle_ready", 32'(z_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("z_b2_tvalid", 32'(z_tvalid), 32'd1);
        check("z_b2_tdata", 32'(z_tdata), 32'h3C);
        check("z_b2_tsrc", 32'(z_tsrc), 32'd0);
        @(posedge clk); #1;
        z_valid = '0;
        z_last  = '0;
        @(negedge clk);
        check("z_end_tvalid", 32'(z_tvalid), 32'd0);
        check("z_end_trunc", 32'(z_trunc), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
